// File: rtl/fetch_pkg.sv
// Shared constants and the queue-entry layout for the fetch queue and its FIFO.
package fetch_pkg;

  localparam int INSTR_W     = 32;
  localparam int PC_STEP     = 4;
  localparam int LINK_OFFSET = 8;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  // Entry layout at the core's standard 10-bit instruction address width.
  localparam int FQ_ADDR_W = 10;

  typedef struct packed {
    logic [INSTR_W-1:0]   instr;
    logic [FQ_ADDR_W-1:0] pc;
  } fq_entry_t;

  function automatic int entry_w(input int addr_w);
    return INSTR_W + addr_w;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular buffer with occupancy count; updates on the falling clock edge.
// Flush empties the queue in one edge by snapping the read pointer onto the write pointer.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 42
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      rptr_q  <= wptr_q;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, reads imem combinationally and queues {instr, pc} for decode.
// Optional FETCH_STATS_EN adds saturating stall_cycles / flush_count outputs.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 10,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_link,
  output logic               full
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_count
`endif
);

  localparam int ENTRY_W = entry_w(ADDR_W);

  // Handshake: decode takes the head on an edge where out_valid & out_ready are
  // both high and no redirect is present; a redirect cancels that edge's transfer.
  logic               push, pop;
  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] head;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               loaded_q, loaded_d;
  logic [ADDR_W-1:0]  head_pc;
  logic [INSTR_W-1:0] head_instr;

  assign out_valid = ~fifo_empty;
  assign full      = fifo_full;
  assign pop       = out_valid & out_ready & ~redirect_valid;
  assign push      = ~redirect_valid & (~fifo_full | pop);
  assign imem_addr = pc_q;

  always_comb begin
    pc_d     = pc_q;
    loaded_d = loaded_q | push;
    if (redirect_valid)  pc_d = redirect_pc & ~ADDR_W'(3);
    else if (push)       pc_d = pc_q + ADDR_W'(PC_STEP);
  end

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q     <= RESET_PC;
      loaded_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      loaded_q <= loaded_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wdata   ({imem_rdata, pc_q}),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head_pc    = head[ADDR_W-1:0];
  assign head_instr = head[ENTRY_W-1 -: INSTR_W];

  // Until the first fetch lands the outputs read as zero, link included.
  assign out_instr = loaded_q ? head_instr : NOP;
  assign out_pc    = loaded_q ? head_pc : '0;
  assign out_link  = loaded_q ? head_pc + ADDR_W'(LINK_OFFSET) : '0;

`ifdef FETCH_STATS_EN
  logic [31:0] stall_q, stall_d, flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (fifo_full && !pop && !redirect_valid && stall_q != '1) stall_d = stall_q + 1'b1;
    if (redirect_valid && flush_q != '1)                       flush_d = flush_q + 1'b1;
  end

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: accepted entries are checked against an expected queue.
module tb_fetch_queue;

  logic        clock;
  logic        reset_n;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [9:0]  out_pc;
  logic [9:0]  out_link;
  logic        full;
`ifdef FETCH_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  int checks = 0;
  int errors = 0;

  // Expected entry: {pc[9:0], instr[31:0], link[9:0]}
  logic [51:0] exp_q[$];

  fetch_queue #(.ADDR_W(10), .DEPTH(4), .RESET_PC(10'h000)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_link       (out_link),
    .full           (full)
`ifdef FETCH_STATS_EN
    ,
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
`endif
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] word_of(input logic [9:0] a);
    return {8'hA5, 14'h0, a};
  endfunction

  assign imem_rdata = word_of(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [9:0] pc);
    logic [9:0] link;
    link = pc + 10'd8;
    exp_q.push_back({pc, word_of(pc), link});
  endtask

  // Inputs change 1 time unit after the rising edge; the DUT updates on the falling edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: an acceptance happens at the next falling edge when this holds.
  initial begin
    logic [51:0] e;
    forever begin
      @(posedge clock);
      #2;
      if (reset_n && out_valid && out_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_accept actual_pc=%h required=none", out_pc);
        end else begin
          e = exp_q.pop_front();
          check("acc_pc",    {22'h0, out_pc},   {22'h0, e[51:42]});
          check("acc_instr", out_instr,         e[41:10]);
          check("acc_link",  {22'h0, out_link}, {22'h0, e[9:0]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // Driver
  initial begin
    reset_n        = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_full",  full,      0);
    check("rst_instr", out_instr, 0);
    check("rst_pc",    out_pc,    0);
    check("rst_link",  out_link,  0);
    check("rst_addr",  imem_addr, 0);

    // Streaming with out_ready high
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(10'(i * 4));
    tick();
    check("p1_first_valid", out_valid, 1);
    check("p1_addr",        imem_addr, 4);
    repeat (3) tick();
    tick();
    out_ready = 1'b0;
    tick();
    check("p1_drain", exp_q.size(), 0);

    // Fill to full with decode stalled, then drain with no bubble
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check("p2_full_1", full, 0);
    tick();
    tick();
    check("p2_full_3", full, 0);
    tick();
    check("p2_full_4", full, 1);
    check("p2_addr_4", imem_addr, 16);
    tick();
    tick();
    check("p2_full_6", full, 1);
    check("p2_addr_6", imem_addr, 16);
    for (int i = 0; i < 5; i++) push_exp(10'(i * 4));
    out_ready = 1'b1;
    repeat (5) begin
      check("p2_no_bubble", out_valid, 1);
      tick();
    end
    out_ready = 1'b0;
    tick();
    check("p2_drain", exp_q.size(), 0);

    // Redirect with 3 entries queued and out_ready high on the same edge
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("p3_pre_valid", out_valid, 1);
    check("p3_pre_full",  full,      0);
    redirect_valid = 1'b1;
    redirect_pc    = 10'h040;
    out_ready      = 1'b1;
    tick();
    check("p3_flush_valid", out_valid, 0);
    check("p3_flush_full",  full,      0);
    check("p3_flush_addr",  imem_addr, 10'h040);
    redirect_valid = 1'b0;
    push_exp(10'h040);
    push_exp(10'h044);
    repeat (3) tick();
    out_ready = 1'b0;
    tick();
    check("p3_drain", exp_q.size(), 0);

    // Misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 10'h043;
    tick();
    check("p4_addr",  imem_addr, 10'h040);
    check("p4_valid", out_valid, 0);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    push_exp(10'h040);
    repeat (2) tick();
    out_ready = 1'b0;
    tick();
    check("p4_drain", exp_q.size(), 0);

    // PC and link wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 10'h3FC;
    tick();
    check("p5_addr", imem_addr, 10'h3FC);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    push_exp(10'h3FC);
    push_exp(10'h000);
    repeat (3) tick();
    out_ready = 1'b0;
    tick();
    check("p5_drain", exp_q.size(), 0);

    // Fill, stall one edge, then assert reset asynchronously
    tick();
    tick();
    check("p6_full", full, 1);
    tick();
    check("p6_full_hold", full, 1);
`ifdef FETCH_STATS_EN
    check("p6_stall_cnt", stall_cycles, 1);
    check("p6_flush_cnt", flush_count,  3);
`endif
    reset_n = 1'b0;
    #1;
    check("p6_async_valid", out_valid, 0);
    check("p6_async_full",  full,      0);
    check("p6_async_addr",  imem_addr, 0);
    check("p6_async_pc",    out_pc,    0);
    check("p6_async_link",  out_link,  0);
`ifdef FETCH_STATS_EN
    check("p6_rst_stall", stall_cycles, 0);
    check("p6_rst_flush", flush_count,  0);
`endif
    redirect_valid = 1'b1;
    redirect_pc    = 10'h100;
    tick();
    check("p6_rst_redirect_addr",  imem_addr, 0);
    check("p6_rst_redirect_valid", out_valid, 0);
    redirect_valid = 1'b0;
    reset_n        = 1'b1;
    tick();
    check("p6_post_addr",  imem_addr, 4);
    check("p6_post_valid", out_valid, 1);
    repeat (2) tick();
    check("final_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the core's single-register fetch stage.
- Owns the PC and drives a combinational instruction-memory read port.
- Buffers fetched instructions and their PCs in a DEPTH-entry queue, then hands them to decode through a valid/ready handshake.
- Decode redirects (branch/jump/jal) flush the queue and reload the PC in one cycle.

Parameters:
- ADDR_W, 10, byte-address width of instruction memory; PC wraps modulo 2^ADDR_W.
- DEPTH, 4, queue entries; power of two, minimum 2.
- RESET_PC, 0, byte address loaded into PC on reset; bits [1:0] must be 0.

Ports:
- clock  in  1  core clock; all state updates on its negative edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_addr  out  ADDR_W  byte address of the word being fetched; equals pc.
- imem_rdata  in  32  word at imem_addr, returned combinationally in the same cycle.
- redirect_valid  in  1  decode requests a PC change.
- redirect_pc  in  ADDR_W  target byte address.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  32  head instruction.
- out_pc  out  ADDR_W  head byte address.
- out_link  out  ADDR_W  out_pc+8 modulo 2^ADDR_W; this is the jal link value.
- full  out  1  count==DEPTH.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - pc=RESET_PC, count=0, read/write pointers=0.
  - out_valid=0, full=0; out_instr, out_pc and out_link read as 0.
- State per entry: {instr[31:0], pc[ADDR_W-1:0]}. Pointers are log2(DEPTH) bits and wrap naturally.
- pop = out_valid & out_ready & ~redirect_valid.
- push = ~redirect_valid & (~full | pop). A push when full is legal only together with a pop in the same edge.
- On push: entry[wptr] <= {imem_rdata, pc}; pc <= pc+4 (mod 2^ADDR_W); wptr++.
- On pop: rptr++.
- count update: +1 on push only, -1 on pop only, unchanged on both.
- Latency: an instruction fetched at edge N is visible at out_* after edge N, so its first acceptance is possible at edge N+1. With out_ready held high, throughput is 1 instruction per cycle.
- Redirect has the highest priority:
  - count <= 0, rptr <= wptr.
  - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; misaligned low bits are forced to 0.
  - No push and no pop that edge, even if out_ready=1 and out_valid=1.
  - No delay slot: instructions younger than the redirecting one are discarded.
- Full without a pop: pc holds, no fetch, imem_addr stays stable.
- Empty: out_valid=0; out_* hold the last entry's values and are don't-care to decode.
- out_instr, out_pc and out_link are combinational from entry[rptr].
- PC wrap: from (2^ADDR_W)-4, pc goes to 0; out_link wraps the same way.
- A redirect while reset_n=0 is ignored; reset dominates.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_count[31:0], both reset to 0 and saturating at 0xFFFFFFFF.
  - stall_cycles increments on every edge with full & ~pop & ~redirect_valid.
  - flush_count increments on every edge with redirect_valid=1.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - INSTR_W=32, PC_STEP=4, LINK_OFFSET=8, NOP=32'h0000_0000.
  - typedef fq_entry_t {instr, pc}, parametrised by ADDR_W through a localparam in the package.
- One sub-module, fetch_fifo (DEPTH, entry width):
  - Storage, pointers, count, full/empty.
  - Inputs push, pop, flush.
- fetch_queue holds the PC, push/pop/redirect arbitration and the link adder.

Test Plan:
- Reset then out_ready=1, imem_rdata=word(addr):
  - out_pc sequence 0,4,8,12; out_link 8,12,16,20.
  - First out_valid=1 one edge after reset release.
- out_ready=0 for 6 cycles, DEPTH=4:
  - full=1 after 4 edges; pc holds at 16.
  - Raising out_ready gives out_pc 0,4,8,12,16 with no bubble.
- Redirect to 0x40 while 3 entries are queued and out_ready=1 on the same edge:
  - Next cycle out_valid=0, count=0.
  - Then out_pc=0x40; no entry is accepted on the redirect edge.
- Redirect to 0x43 -> first out_pc=0x40.
- ADDR_W=10, redirect to 0x3FC:
  - out_pc 0x3FC then 0x000.
  - out_link for 0x3FC is 0x004.
- Assert reset_n=0 asynchronously with the queue full:
  - out_valid and full drop before the next edge; pc=RESET_PC.
  - With FETCH_STATS_EN, both counters read 0.
